rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3, is the number of consecutive stalled cycles of the long-latency port before that port is promoted to priority.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 p_valid  input  1  pipeline writeback request.
REQ-005 p_rd  input  5  pipeline destination register.
REQ-006 p_data  input  32  pipeline write data.
REQ-007 p_ready  output  1  pipeline request accepted this cycle.
REQ-008 m_valid  input  1  long-latency unit (mul/div) writeback request.
REQ-009 m_rd  input  5  long-latency destination register.
REQ-010 m_data  input  32  long-latency write data.
REQ-011 m_ready  output  1  long-latency request accepted this cycle.
REQ-012 RFWr  output  1  register-file write enable.
REQ-013 A3  output  5  register-file write address.
REQ-014 WD  output  32  register-file write data.
REQ-015 m_starved  output  1  high while the FSM is in PRIO_M; drives a pipeline stall.

Function
REQ-016 A transfer occurs on a port in a cycle where both valid and ready are high; a requester holds valid, rd and data stable until accepted.
REQ-017 FSM states: PRIO_P (pipeline wins conflicts) and PRIO_M (long-latency port wins conflicts).
REQ-018 In PRIO_P: p_ready = p_valid; m_ready = m_valid & ~p_valid.
REQ-019 In PRIO_M: m_ready = m_valid; p_ready = p_valid & ~m_valid.
REQ-020 At most one of p_ready and m_ready is high in any cycle.
REQ-021 A 2-bit-or-wider wait counter increments in each cycle with m_valid & ~m_ready, saturating at STARVE_MAX; it clears on any m transfer or when m_valid is low.
REQ-022 Transition PRIO_P->PRIO_M occurs at the clock edge where the counter equals STARVE_MAX-1 and increments.
REQ-023 Transition PRIO_M->PRIO_P occurs on the edge following an m transfer, or if m_valid is low in PRIO_M.
REQ-024 Write latency is exactly one cycle: a transfer in cycle N yields RFWr=1 with A3/WD equal to the accepted rd/data in cycle N+1, for one cycle only.
REQ-025 A transfer with rd==0 is accepted normally, but RFWr stays 0 in cycle N+1 (x0 is never written).
REQ-026 With no transfer in cycle N, RFWr=0 in cycle N+1, and A3/WD hold their previous values.
REQ-027 When both ports target the same rd, the write that completes later determines the final register value; the arbiter never merges or drops a nonzero-rd write.
REQ-028 Back-to-back transfers on consecutive cycles are supported, giving one write per cycle.

Reset
REQ-029 While rst=0: state=PRIO_P, counter=0, RFWr=0, A3=0, WD=0, and m_starved=0.
REQ-030 p_ready and m_ready follow REQ-018 from PRIO_P during reset; any acceptance during reset is discarded.
REQ-031 Reset asserted mid-operation cancels any pending registered write immediately, without waiting for a clock edge.

Structure
REQ-032 REG_ZERO (5'd0), the STARVE_MAX default and the FSM state encoding reside in the shared CPU defines package.
REQ-033 No sub-module is required; the RFWr/A3/WD outputs connect directly to the rf write port at core level.

Verification
REQ-034 Scenario 1: p_valid=1, p_rd=5, p_data=0x1234 only -> p_ready=1 in the same cycle; next cycle RFWr=1, A3=5, WD=0x1234.
REQ-035 Scenario 2: p_valid held high with m_valid=1, m_rd=7, m_data=0xDEAD (STARVE_MAX=3) -> m_ready=0 for 3 cycles, then PRIO_M with m_starved=1; m_ready=1 and p_ready=0 in cycle 4; RFWr with A3=7 in cycle 5; back to PRIO_P in cycle 5.
REQ-036 Scenario 3: m_valid alone, m_rd=0 -> m_ready=1, and RFWr remains 0 the next cycle.
REQ-037 Scenario 4: p transfers to rd=3 on 4 consecutive cycles with data 1,2,3,4 -> RFWr high for 4 consecutive cycles, and WD sequence is 1,2,3,4.
REQ-038 Scenario 5: rst pulsed low in the cycle after a transfer -> RFWr drops to 0 asynchronously, and the state returns to PRIO_P with counter=0.
REQ-039 Scenario 6: in PRIO_M, both ports target rd=9 (p_data=0xA, m_data=0xB) -> the m write (0xB) is issued first, then the p write (0xA), and the final rf[9]=0xA.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU defines for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned RD_W           = 5;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned STARVE_MAX_DEF = 3;

  // Architectural zero register: never written.
  localparam logic [RD_W-1:0] REG_ZERO = RD_W'(0);

  // Arbitration priority state.
  typedef enum logic {
    PRIO_P = 1'b0,
    PRIO_M = 1'b1
  } arb_state_e;

  // Writeback payload as seen by the register-file write port.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage : rf_wb_arbiter_pkg

// File: rtl/rf_wb_arbiter.sv
// Two-port register-file writeback arbiter with starvation promotion of the
// long-latency (mul/div) port and a one-cycle registered write path.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic [RD_W-1:0]   p_rd,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_ready,
  input  logic              m_valid,
  input  logic [RD_W-1:0]   m_rd,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              RFWr,
  output logic [RD_W-1:0]   A3,
  output logic [DATA_W-1:0] WD,
  output logic              m_starved
);

  localparam int unsigned    CNT_W   = (STARVE_MAX >= 4) ? $clog2(STARVE_MAX + 1) : 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STARVE_MAX - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [RD_W-1:0]   a3_q, a3_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic    p_xfer, m_xfer, m_stall;
  wb_req_t sel;

  // Grant: current priority holder wins a conflict; the other port waits.
  always_comb begin
    p_ready = p_valid;
    m_ready = m_valid & ~p_valid;
    if (state_q == PRIO_M) begin
      m_ready = m_valid;
      p_ready = p_valid & ~m_valid;
    end
  end

  assign p_xfer  = p_valid & p_ready;
  assign m_xfer  = m_valid & m_ready;
  assign m_stall = m_valid & ~m_ready;
  assign sel     = m_xfer ? wb_req_t'{rd: m_rd, data: m_data}
                          : wb_req_t'{rd: p_rd, data: p_data};

  // Wait counter and priority state transitions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!m_valid || m_xfer) begin
      cnt_d = '0;
    end else if (m_stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      PRIO_P: if (m_stall && (cnt_q == CNT_PRE)) state_d = PRIO_M;
      PRIO_M: if (m_xfer || !m_valid) state_d = PRIO_P;
      default: state_d = PRIO_P;
    endcase
  end

  // Registered write port: x0 targets are accepted but suppressed; address
  // and data hold their last written values when no write issues.
  always_comb begin
    wr_en_d = (p_xfer || m_xfer) && (sel.rd != REG_ZERO);
    a3_d    = wr_en_d ? sel.rd   : a3_q;
    wd_d    = wr_en_d ? sel.data : wd_q;
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PRIO_P;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      a3_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
    end
  end

  assign RFWr      = wr_en_q;
  assign A3        = a3_q;
  assign WD        = wd_q;
  assign m_starved = (state_q == PRIO_M);

endmodule : rf_wb_arbiter
